fsm_hash2matrix: RTL

// - Receive side of the sha3 word framing: consumes the 64-bit word stream from the hash output FIFO.
// - Framing: one header word 64'h8000_0000_0000_0100, then WORDS payload words.
// - Checks and strips the header, assembles the payload into one 256-bit digest.
// - Hands the digest to the matrix input stage over a valid/ready handshake.

---
 rtl/obtc_pkg.sv | 8 +
 rtl/fsm_hash2matrix_if.sv | 20 ++
 rtl/fsm_hash2matrix.sv | 63 ++++++
 3 files changed

// File: rtl/obtc_pkg.sv
// obtc_pkg: sha3 word-framing constants and state type, shared by the transmit and receive framing blocks
package obtc_pkg;
  localparam int DATA_W = 64;
  localparam int HASH_WORDS = 4;
  localparam int HASH_W = 256;
  localparam logic [DATA_W-1:0] SHA3_HDR = 64'h8000000000000100;
  typedef enum logic [1:0] {IDLE, DATA, HOLD} h2m_state_t;
endpackage

// File: rtl/fsm_hash2matrix_if.sv
// fsm_hash2matrix_if: word stream in from the hash FIFO, digest out to the matrix stage
interface fsm_hash2matrix_if;
  import obtc_pkg::*;
  logic din_valid;
  logic [DATA_W-1:0] din;
  logic din_ready;
  logic hash_ready;
  logic hash_valid;
  logic [HASH_W-1:0] hash_out;
  logic hdr_err;
  logic [31:0] pkt_cnt;
  modport master (
    output din_valid, din, hash_ready,
    input  din_ready, hash_valid, hash_out, hdr_err, pkt_cnt
  );
  modport slave (
    input  din_valid, din, hash_ready,
    output din_ready, hash_valid, hash_out, hdr_err, pkt_cnt
  );
endinterface

// File: rtl/fsm_hash2matrix.sv
// fsm_hash2matrix: checks and strips the sha3 header word and assembles the payload into one digest
module fsm_hash2matrix
  import obtc_pkg::*;
(
  input logic clk,
  input logic rst,
  fsm_hash2matrix_if.slave bus
);
  h2m_state_t state;
  logic [1:0] idx;
  logic din_ready_q;
  logic hash_valid_q;
  logic hdr_err_q;
  logic [HASH_W-1:0] hash_q;
  logic [31:0] pkt_cnt_q;
  logic xfer;
  assign xfer = bus.din_valid & din_ready_q;
  assign bus.din_ready = din_ready_q;
  assign bus.hash_valid = hash_valid_q;
  assign bus.hash_out = hash_q;
  assign bus.hdr_err = hdr_err_q;
  assign bus.pkt_cnt = pkt_cnt_q;
  // framing FSM; payload word idx lands at bits {~idx,6'h3f} down, so the first word is the MSW
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      din_ready_q <= 1'b0;
      hash_valid_q <= 1'b0;
      hdr_err_q <= 1'b0;
      hash_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      hdr_err_q <= 1'b0;
      case (state)
        IDLE: begin
          din_ready_q <= 1'b1;
          if (xfer) begin
            if (bus.din == SHA3_HDR) begin
              state <= DATA;
              idx <= '0;
            end else hdr_err_q <= 1'b1;
          end
        end
        DATA: if (xfer) begin
          hash_q[{~idx, 6'h3f} -: DATA_W] <= bus.din;
          idx <= idx + 2'd1;
          if (idx == 2'(HASH_WORDS - 1)) begin
            state <= HOLD;
            din_ready_q <= 1'b0;
            hash_valid_q <= 1'b1;
          end
        end
        HOLD: if (hash_valid_q && bus.hash_ready) begin
          hash_valid_q <= 1'b0;
          pkt_cnt_q <= pkt_cnt_q + 32'd1;
          state <= IDLE;
          din_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
